// File: rtl/marc_pkg.sv
// marc_pkg -- shared definitions for the MARC multi-cycle processor.
//   Width constants : DATA_W (16-bit datapath), REG_IDX_W (3-bit register index)
//   Encodings       : opcodes, branch conditions, FSM states
//   Types           : flagsT (N, Z, V, C)
//   Helpers         : signExt4 / signExt8 immediate sign extension
package marc_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;

    typedef enum logic [3:0] {
        OP_NOP    = 4'b0000,
        OP_AND    = 4'b0001,
        OP_OR     = 4'b0010,
        OP_ADDCC  = 4'b0011,
        OP_ADD    = 4'b0100,
        OP_SUBCC  = 4'b0101,
        OP_LD     = 4'b0110,
        OP_ST     = 4'b0111,
        OP_SUB    = 4'b1000,
        OP_BR     = 4'b1001,
        OP_SETLOW = 4'b1010,
        OP_SETHI  = 4'b1011
    } opcodeT;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'b000,
        COND_ALWAYS = 3'b001,
        COND_Z      = 3'b010,
        COND_NZ     = 3'b011,
        COND_N      = 3'b100,
        COND_C      = 3'b101,
        COND_V      = 3'b110,
        COND_LT     = 3'b111
    } condT;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4
    } stateT;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flagsT;

    function automatic logic [DATA_W-1:0] signExt4(input logic [3:0] value);
        return {{(DATA_W-4){value[3]}}, value};
    endfunction

    function automatic logic [DATA_W-1:0] signExt8(input logic [7:0] value);
        return {{(DATA_W-8){value[7]}}, value};
    endfunction

endpackage

// File: rtl/marc_alu.sv
// marc_alu -- combinational ALU and flag generation for MARC.
//   op        : decoded opcode (already forced to nop for invalid words)
//   a, b      : rs1 value and second operand (simm4 or rs2)
//   imm8      : 8-bit immediate for setlow/sethi
//   result    : ALU result; ld/st use the a+b sum as effective address
//   flagsOut  : N, Z, V, C computed from this operation
//   setsFlags : high only for addcc/subcc
module marc_alu
    import marc_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [7:0]        imm8,
    output logic [DATA_W-1:0] result,
    output flagsT             flagsOut,
    output logic              setsFlags
);

    logic [DATA_W:0] sumFull;
    logic [DATA_W:0] diffFull;

    always_comb begin
        sumFull   = {1'b0, a} + {1'b0, b};
        // Extra top bit of the zero-extended difference is the borrow.
        diffFull  = {1'b0, a} - {1'b0, b};
        result    = '0;
        flagsOut  = '0;
        setsFlags = 1'b0;

        case (op)
            OP_AND:                         result = a & b;
            OP_OR:                          result = a | b;
            OP_ADDCC, OP_ADD, OP_LD, OP_ST: result = sumFull[DATA_W-1:0];
            OP_SUBCC, OP_SUB:               result = diffFull[DATA_W-1:0];
            OP_SETLOW:                      result = {{(DATA_W-8){1'b0}}, imm8};
            OP_SETHI:                       result = {imm8, {(DATA_W-8){1'b0}}};
            default:                        result = '0;
        endcase

        flagsOut.n = result[DATA_W-1];
        flagsOut.z = (result == '0);
        if (op == OP_ADDCC) begin
            setsFlags  = 1'b1;
            flagsOut.c = sumFull[DATA_W];
            // Overflow: operands agree in sign but the result does not.
            flagsOut.v = (a[DATA_W-1] == b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
        end else if (op == OP_SUBCC) begin
            setsFlags  = 1'b1;
            flagsOut.c = diffFull[DATA_W];
            // Overflow: operands differ in sign and the result flips from a.
            flagsOut.v = (a[DATA_W-1] != b[DATA_W-1]) && (result[DATA_W-1] != a[DATA_W-1]);
        end
    end

endmodule

// File: rtl/marc_processor.sv
// marc_processor -- 5-clock multi-cycle MARC CPU
// (FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK).
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low
//   dataIn : instruction word in FETCH, load data in MEMORY
//   busA   : memory address (PC, or effective address during a ld/st MEMORY cycle)
//   busB   : store data, 0 when not storing
//   rw     : 1 = write, asserted for the single MEMORY clock of a st
// Build option: define MARC_LOAD_EN to include the ld instruction;
// without it opcode 0110 executes as nop and dataIn is ignored outside FETCH.
module marc_processor
    import marc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic              rw
);

    stateT             state;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] regs [NUM_REGS];
    flagsT             flags;

    logic [3:0]           op;
    logic [REG_IDX_W-1:0] rdIdx;
    logic [REG_IDX_W-1:0] rs1Idx;
    logic [REG_IDX_W-1:0] rs2Idx;
    logic [2:0]           cond;
    logic [7:0]           imm8;
    logic [DATA_W-1:0]    rs1Val;
    logic [DATA_W-1:0]    rs2Val;
    logic [DATA_W-1:0]    rdVal;
    logic [DATA_W-1:0]    op2;
    logic [DATA_W-1:0]    aluResult;
    logic [DATA_W-1:0]    wbData;
    logic [DATA_W-1:0]    nextPc;
    flagsT                aluFlags;
    logic                 aluSetsFlags;
    logic                 branchTaken;
    logic                 isAluWrite;
    logic                 isStore;
    logic                 isLoad;
    logic                 writesRd;

`ifdef MARC_LOAD_EN
    logic [DATA_W-1:0] loadData;
`endif

    // Decode: IR is stable from DECODE through WRITEBACK, and registers and
    // flags only change at the end of WRITEBACK, so everything below can stay
    // combinational for the whole instruction.
    always_comb begin
        op = ir[DATA_W-1] ? 4'(OP_NOP) : ir[14:11];
`ifndef MARC_LOAD_EN
        if (op == OP_LD) op = 4'(OP_NOP);
`endif
        rdIdx  = ir[10:8];
        cond   = ir[10:8];
        rs1Idx = ir[7:5];
        rs2Idx = ir[2:0];
        imm8   = ir[7:0];

        rs1Val = (rs1Idx == '0) ? '0 : regs[rs1Idx];
        rs2Val = (rs2Idx == '0) ? '0 : regs[rs2Idx];
        rdVal  = (rdIdx  == '0) ? '0 : regs[rdIdx];
        op2    = ir[4] ? signExt4(ir[3:0]) : rs2Val;

        case (cond)
            COND_NEVER:  branchTaken = 1'b0;
            COND_ALWAYS: branchTaken = 1'b1;
            COND_Z:      branchTaken = flags.z;
            COND_NZ:     branchTaken = !flags.z;
            COND_N:      branchTaken = flags.n;
            COND_C:      branchTaken = flags.c;
            COND_V:      branchTaken = flags.v;
            default:     branchTaken = flags.n ^ flags.v;
        endcase

        // Branch displacement is relative to the branch's own address.
        if (op == OP_BR && branchTaken) nextPc = pc + signExt8(imm8);
        else                            nextPc = pc + DATA_W'(2);

        case (op)
            OP_AND, OP_OR, OP_ADDCC, OP_ADD, OP_SUBCC, OP_SUB, OP_SETLOW, OP_SETHI:
                isAluWrite = 1'b1;
            default:
                isAluWrite = 1'b0;
        endcase
        isStore = (op == OP_ST);
`ifdef MARC_LOAD_EN
        isLoad = (op == OP_LD);
        wbData = isLoad ? loadData : aluResult;
`else
        isLoad = 1'b0;
        wbData = aluResult;
`endif
        writesRd = (rdIdx != '0) && (isAluWrite || isLoad);
    end

    marc_alu u_alu (
        .op        (op),
        .a         (rs1Val),
        .b         (op2),
        .imm8      (imm8),
        .result    (aluResult),
        .flagsOut  (aluFlags),
        .setsFlags (aluSetsFlags)
    );

    // FSM, register file, PC and registered bus outputs. Bus values are
    // loaded one edge ahead of the state that shows them, so the async
    // reset clears busA/busB/rw immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
            pc    <= '0;
            ir    <= '0;
            flags <= '0;
            busA  <= '0;
            busB  <= '0;
            rw    <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
`ifdef MARC_LOAD_EN
            loadData <= '0;
`endif
        end else begin
            case (state)
                ST_FETCH: begin
                    ir    <= dataIn;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    state <= ST_MEMORY;
                    if (isStore || isLoad) begin
                        busA <= aluResult;
                        busB <= isStore ? rdVal : '0;
                        rw   <= isStore;
                    end
                end
                ST_MEMORY: begin
                    state <= ST_WRITEBACK;
                    busA  <= pc;
                    busB  <= '0;
                    rw    <= 1'b0;
`ifdef MARC_LOAD_EN
                    if (isLoad) loadData <= dataIn;
`endif
                end
                ST_WRITEBACK: begin
                    state <= ST_FETCH;
                    pc    <= nextPc;
                    busA  <= nextPc;
                    if (writesRd)     regs[rdIdx] <= wbData;
                    if (aluSetsFlags) flags       <= aluFlags;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_marc_processor.sv
// tb_marc_processor -- self-checking bench for marc_processor.
// The bench is the memory (read-only program/data array). An instruction-level
// model (PC, r0..r7, N/Z/V/C) predicts each instruction's 5-cycle bus trace;
// directed programs pin the model with literal values, then random programs
// exercise the whole instruction set.
`timescale 1ns/1ps
module tb_marc_processor;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic [15:0] dataIn = 16'h0000;
    logic [15:0] busA;
    logic [15:0] busB;
    logic        rw;

    marc_processor dut (
        .clk    (clk),
        .reset  (reset),
        .dataIn (dataIn),
        .busA   (busA),
        .busB   (busB),
        .rw     (rw)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:32767];

    int tests = 0;
    int fails = 0;

    logic [15:0] mPc;
    logic [15:0] mReg [8];
    logic        mN, mZ, mV, mC;
    logic [15:0] stA, stB;

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (model pc %h)", name, act, exp, mPc);
        end
    endfunction

    function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int i, input int low);
        return {1'b0, 4'(op), 3'(rd), 3'(rs1), 1'(i), 4'(low)};
    endfunction

    function automatic logic [15:0] encImm8(input int op, input int rd, input int imm);
        return {1'b0, 4'(op), 3'(rd), 8'(imm)};
    endfunction

    function automatic logic [15:0] rreg(input logic [2:0] idx);
        return (idx == 3'd0) ? 16'h0000 : mReg[idx];
    endfunction

    function automatic void wreg(input logic [2:0] idx, input logic [15:0] val);
        if (idx != 3'd0) mReg[idx] = val;
    endfunction

    function automatic bit condTrue(input logic [2:0] c);
        case (c)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return mZ;
            3'd3: return !mZ;
            3'd4: return mN;
            3'd5: return mC;
            3'd6: return mV;
            default: return mN ^ mV;
        endcase
    endfunction

    function automatic void resetModel();
        mPc = 16'h0000;
        for (int k = 0; k < 8; k++) mReg[k] = 16'h0000;
        {mN, mZ, mV, mC} = 4'b0000;
    endfunction

    // Runs phases 0..lastPhase of the instruction at mPc, checking the bus at
    // each falling edge; the model state advances only for a complete instruction.
    task automatic runInstr(input int lastPhase);
        logic [15:0] ins, a, b, rdv, ea, res, np;
        int op, sa, sb, ss;
        ins = mem[mPc[15:1]];
        op  = ins[15] ? 0 : int'(ins[14:11]);
`ifndef MARC_LOAD_EN
        if (op == 6) op = 0;
`endif
        a   = rreg(ins[7:5]);
        b   = ins[4] ? {{12{ins[3]}}, ins[3:0]} : rreg(ins[2:0]);
        rdv = rreg(ins[10:8]);
        ea  = a + b;
        for (int ph = 0; ph <= lastPhase; ph++) begin
            @(negedge clk);
            if (ph == 3 && (op == 6 || op == 7)) begin
                check("mem_busA", busA, ea);
                check("mem_busB", busB, (op == 7) ? rdv : 16'h0000);
                check("mem_rw", {15'b0, rw}, (op == 7) ? 16'd1 : 16'd0);
                if (op == 7) begin
                    stA = busA;
                    stB = busB;
                end
            end else begin
                if (ph != 3) check("pc_busA", busA, mPc);
                check("idle_busB", busB, 16'h0000);
                check("idle_rw", {15'b0, rw}, 16'd0);
            end
            dataIn = mem[busA[15:1]];
        end
        if (lastPhase == 4) begin
            np = mPc + 16'd2;
            sa = $signed(a);
            sb = $signed(b);
            case (op)
                1: wreg(ins[10:8], a & b);
                2: wreg(ins[10:8], a | b);
                3: begin
                    res = a + b;
                    ss  = sa + sb;
                    mN = res[15]; mZ = (res == 16'h0000);
                    mV = (ss > 32767) || (ss < -32768);
                    mC = (int'(a) + int'(b)) > 65535;
                    wreg(ins[10:8], res);
                end
                4: wreg(ins[10:8], a + b);
                5: begin
                    res = a - b;
                    ss  = sa - sb;
                    mN = res[15]; mZ = (res == 16'h0000);
                    mV = (ss > 32767) || (ss < -32768);
                    mC = int'(a) < int'(b);
                    wreg(ins[10:8], res);
                end
                6: wreg(ins[10:8], mem[ea[15:1]]);
                8: wreg(ins[10:8], a - b);
                9: if (condTrue(ins[10:8])) np = mPc + {{8{ins[7]}}, ins[7:0]};
                10: wreg(ins[10:8], {8'h00, ins[7:0]});
                11: wreg(ins[10:8], {ins[7:0], 8'h00});
                default: ;
            endcase
            mPc = np;
        end
    endtask

    task automatic runN(input int n);
        for (int k = 0; k < n; k++) runInstr(4);
    endtask

    // Holds reset low for some clocks, then releases just after a rising edge
    // so the next rising edge is the first one that sees reset high.
    task automatic doReset(input int cycles);
        reset = 1'b0;
        resetModel();
        repeat (cycles) @(negedge clk);
        check("rst_busA", busA, 16'h0000);
        check("rst_busB", busB, 16'h0000);
        check("rst_rw", {15'b0, rw}, 16'd0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        dataIn = mem[0];
    endtask

    task automatic afterBranch(input string name, input logic [15:0] target);
        @(posedge clk);
        #1;
        check(name, busA, target);
    endtask

    initial begin
        // Program 1: branch over two nops, multiply 15*3 by repeated add, store.
        for (int k = 0; k < 32768; k++) mem[k] = 16'h0000;
        mem[0]  = encImm8(10, 1, 15);          // setlow 15,%r1
        mem[1]  = encImm8(10, 2, 3);           // setlow 3,%r2
        mem[2]  = encImm8(9, 1, 6);            // ba 6      -> 10
        mem[5]  = enc(4, 4, 4, 0, 1);          // add %r4,%r1,%r4
        mem[6]  = enc(4, 3, 3, 1, 1);          // add %r3,1,%r3
        mem[7]  = enc(5, 0, 3, 0, 2);          // subcc %r3,%r2,%r0
        mem[8]  = encImm8(9, 7, -6);           // bl -6     -> 10
        mem[9]  = encImm8(11, 6, 8);           // sethi 8,%r6
        mem[10] = enc(7, 4, 6, 1, 0);          // st %r4,[%r6]

        doReset(5);
        check("first_fetch_busA", busA, 16'h0000);
        runN(3);
        afterBranch("ba_target", 16'd10);
        check("ba_model_pc", mPc, 16'd10);
        runN(14);
        check("mul_st_busA", stA, 16'h0800);
        check("mul_st_busB", stB, 16'h002D);
        check("mul_model_r4", mReg[4], 16'd45);

        // Program 2: immediates, r0 behaviour, flags and conditional branches.
        reset = 1'b0;
        for (int k = 0; k < 32768; k++) mem[k] = 16'h0000;
        mem[0]  = encImm8(10, 5, 255);         // setlow 255,%r5
        mem[1]  = enc(7, 5, 0, 1, 0);          // st %r5,[%r0]
        mem[2]  = enc(4, 0, 0, 1, 5);          // add %r0,5,%r0
        mem[3]  = enc(7, 0, 0, 1, 0);          // st %r0,[%r0]
        mem[4]  = enc(5, 1, 0, 1, 1);          // subcc %r0,1,%r1
        mem[5]  = encImm8(9, 4, 4);            // bn +4     -> 14
        mem[7]  = encImm8(9, 5, 4);            // bcs +4    -> 18
        mem[9]  = enc(5, 0, 1, 0, 1);          // subcc %r1,%r1,%r0
        mem[10] = encImm8(9, 2, 4);            // be +4     -> 24
        mem[12] = enc(7, 1, 0, 1, 2);          // st %r1,[%r0+2]

        doReset(3);
        runN(2);
        check("setlow_st_busB", stB, 16'h00FF);
        runN(2);
        check("r0_st_busB", stB, 16'h0000);
        runN(1);
        check("subcc_flags_NZVC", {12'b0, mN, mZ, mV, mC}, 16'h0009);
        check("subcc_model_r1", mReg[1], 16'hFFFF);
        runN(1);
        afterBranch("bn_target", 16'd14);
        runN(1);
        afterBranch("bcs_target", 16'd18);
        runN(2);
        afterBranch("be_target", 16'd24);

        // Store stopped in its MEMORY cycle by an asynchronous reset.
        runInstr(3);
        check("st_rw_before_reset", {15'b0, rw}, 16'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rw", {15'b0, rw}, 16'd0);
        check("async_busA", busA, 16'h0000);
        check("async_busB", busB, 16'h0000);

        // Random programs across the full address space.
        for (int pass = 0; pass < 2; pass++) begin
            reset = 1'b0;
            for (int k = 0; k < 32768; k++) begin
                logic [15:0] w;
                w = 16'($urandom);
                if ($urandom_range(3) != 0) w[15] = 1'b0;
                mem[k] = w;
            end
            doReset(2);
            runN(250);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/marc_processor.md
MARC_PROCESSOR -- requirements
Module: marc_processor

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock, all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low; 0 = reset asserted.
REQ-003 SHALL have port dataIn, input, 16 bits: instruction word during FETCH, load data during MEMORY.
REQ-004 SHALL have port busA, output, 16 bits: memory address (PC, or effective address for ld/st).
REQ-005 SHALL have port busB, output, 16 bits: store data, 0 when not storing.
REQ-006 SHALL have port rw, output, 1 bit: 1 = memory write, 0 = read.

Function
REQ-007 SHALL be multi-cycle, 5 clocks per instruction, states FETCH->DECODE->EXECUTE->MEMORY->WRITEBACK->FETCH, no stalls.
REQ-008 SHALL hold 8 x 16-bit registers r0..r7; r0 reads 0 and writes to it are discarded; 16-bit byte-addressed PC; flags N,Z,V,C.
REQ-009 SHALL latch IR <= dataIn at the rising edge ending FETCH; busA = PC in FETCH, DECODE, EXECUTE and WRITEBACK.
REQ-010 SHALL decode: bit15 = 0 valid (bit15 = 1 executes as nop), op = [14:11], rd/cond = [10:8], rs1 = [7:5], i = [4], simm4 = [3:0] sign-extended, rs2 = [2:0], bit3 ignored when i = 0, imm8/disp8 = [7:0].
REQ-011 SHALL implement ALU ops with op2 = i ? simm4 : rs2: 0001 and, 0010 or, 0011 addcc, 0100 add, 0101 subcc, 1000 sub; 0000 and undefined opcodes = nop.
REQ-012 SHALL set flags only for addcc/subcc: N = result[15]; Z = result == 0; V = signed overflow; C = carry-out (add) or borrow (sub); all arithmetic modulo 2^16.
REQ-013 SHALL implement setlow (1010): rd <= {8'h00, imm8}; sethi (1011): rd <= {imm8, 8'h00}.
REQ-014 SHALL implement branch (1001) with cond: 000 never, 001 always, 010 Z, 011 !Z, 100 N, 101 C, 110 V, 111 N^V; taken: PC <= PC + sext(disp8) (PC = branch address); else PC <= PC + 2.
REQ-015 SHALL implement st (0111): in MEMORY, busA = rs1 + op2, busB = rd, rw = 1 for exactly one clock.
REQ-016 SHALL implement ld (0110, see REQ-021): in MEMORY, busA = rs1 + op2, rw = 0; rd <= dataIn sampled at the edge ending MEMORY.
REQ-017 SHALL write rd and update PC at the edge ending WRITEBACK; non-branches PC <= PC + 2 (wraps at 16'hFFFE -> 0); busA shows the new PC from the following FETCH.

Reset
REQ-018 SHALL on reset = 0 immediately clear PC, IR, r1..r7, flags and state to FETCH, and drive busA = 0, busB = 0, rw = 0.
REQ-019 SHALL abort any in-flight instruction on mid-instruction reset; a store in progress deasserts rw without waiting for a clock edge.
REQ-020 SHALL begin FETCH at address 0 on the first rising edge after reset returns to 1.

Configuration
REQ-021 SHALL compile the ld instruction only when macro MARC_LOAD_EN is defined; otherwise opcode 0110 is a nop and dataIn is ignored outside FETCH.

Structure
REQ-022 SHALL place opcode, condition and state encodings plus width constants (data 16, register-index 3) in a shared package marc_pkg.
REQ-023 SHALL isolate the combinational ALU and flag logic in a sub-module marc_alu; the register file, FSM and PC stay in marc_processor.

Verification
REQ-024 Reset: hold reset = 0 for 5 clocks -> busA = 0, busB = 0, rw = 0; release -> first fetch at busA = 0.
REQ-025 Branch: setlow 15,%r1 @0; setlow 3,%r2 @2; ba 6 @4 -> busA = 10 after the ba window.
REQ-026 Multiply loop: r1 = 15, r2 = 3; body add r4 += r1; add r3 += 1; subcc r3,r2,r0; bl -6 -> branch taken twice, falls through once; then sethi 8,%r6; st %r4,%r6 -> rw = 1, busA = 0x0800, busB = 0x002D.
REQ-027 Immediates and r0: setlow 255,%r5 then st -> busB = 0x00FF; add %r0,5,%r0 then st %r0 -> busB = 0.
REQ-028 Flags: subcc 0 - 1 -> N = 1, C = 1, Z = 0; subcc equal operands then be +4 -> taken, PC += 4.
REQ-029 Async reset: assert reset mid-st (MEMORY state) -> rw = 0 and busA = 0 within the same cycle, no clock edge needed.
